// File: rtl/prio_mux_reg_if.sv
// Bus bundle for prio_mux_reg: NUM_IN request channels in, one registered beat out.
// Latency: none (wires only).
// Backpressure: in_ready per channel, out_ready from the consumer.
interface prio_mux_reg_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_ready;

  // The arbiter itself: consumes requests and drives the output register.
  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  // The surroundings: sources and the downstream consumer.
  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/prio_mux_reg.sv
// Registered N-way priority select (fixed or round-robin) with winning index report.
// Latency: 1 cycle from accepted request to out_valid; full throughput, no bubble on drain+fill.
// Backpressure: single register, no skid; in_ready all zero while out_valid && !out_ready.
// Optional: define PRIO_MUX_RR_EN to build the rr_ptr register and honour rr_mode.
module prio_mux_reg #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rr_mode,
  prio_mux_reg_if.master       bus
);

  // Lowest-index set bit of v; zero when v is empty (caller qualifies with |v).
  function automatic logic [SEL_W-1:0] first_set(input logic [NUM_IN-1:0] v);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (v[i]) r = i[SEL_W-1:0];
    end
    return r;
  endfunction

  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic [SEL_W-1:0]  out_sel_q;
  logic              any_req;
  logic              load;
  logic              grant_ok;
  logic [SEL_W-1:0]  winner;
  logic [WIDTH-1:0]  win_data;

  assign any_req = |bus.in_valid;
  assign load    = !out_valid_q || bus.out_ready;
  // Gated by reset_n so no source sees a handshake that the held-in-reset register would drop.
  assign grant_ok = reset_n && load && any_req;

`ifdef PRIO_MUX_RR_EN
  logic [SEL_W-1:0]  rr_ptr;
  logic [NUM_IN-1:0] hi_mask;
  logic [NUM_IN-1:0] hi_req;
  logic [SEL_W-1:0]  rr_next;

  // Round-robin = first requester at or above rr_ptr, else wrap to the lowest requester.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      hi_mask[i] = (i >= int'(rr_ptr));
    end
    hi_req = bus.in_valid & hi_mask;
    if (rr_mode && (|hi_req)) winner = first_set(hi_req);
    else                      winner = first_set(bus.in_valid);
  end

  // Explicit wrap keeps the pointer below NUM_IN for non-power-of-two channel counts.
  assign rr_next = (int'(winner) == NUM_IN - 1) ? '0 : winner + SEL_W'(1);

  // Pointer advances past the winner only on a round-robin transfer; kept across mode switches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (rr_mode && load && any_req) begin
      rr_ptr <= rr_next;
    end
  end
`else
  logic unused_rr_mode;
  assign unused_rr_mode = rr_mode;

  // Fixed priority only: lowest requesting index wins.
  always_comb begin
    winner = first_set(bus.in_valid);
  end
`endif

  // One-hot acceptance towards the winner and the matching data lane.
  always_comb begin
    bus.in_ready = '0;
    win_data     = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (winner == i[SEL_W-1:0]) begin
        bus.in_ready[i] = grant_ok;
        win_data        = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register: load on empty or drain; data/sel hold when nothing is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else if (load) begin
      out_valid_q <= any_req;
      if (any_req) begin
        out_data_q <= win_data;
        out_sel_q  <= winner;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_prio_mux_reg.sv
// Directed bench for prio_mux_reg: a 4-channel and a 3-channel instance.
// Latency: each step checks in_ready before the edge and the register 1ns after it.
// Backpressure: exercised through out_ready stalls in the vector table.
module tb_prio_mux_reg;

  logic clk = 1'b0;
  logic reset_n;
  logic rr4;
  logic rr3;
  int   nvec = 0;
  int   nfail = 0;

  logic [31:0] chdat [4];

  prio_mux_reg_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) b4 ();
  prio_mux_reg_if #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) b3 ();

  prio_mux_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u4 (
    .clk(clk), .reset_n(reset_n), .rr_mode(rr4), .bus(b4)
  );
  prio_mux_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) u3 (
    .clk(clk), .reset_n(reset_n), .rr_mode(rr3), .bus(b3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] irdy;
    logic       ov;
    logic [1:0] sel;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive u4 for one cycle; out_data is expected to be the data of channel exp_sel.
  task automatic step4(input string tag, input logic [3:0] iv, input logic ordy, input logic rr,
                       input logic [3:0] exp_irdy, input logic exp_ov, input logic [1:0] exp_sel);
    b4.in_valid  = iv;
    b4.out_ready = ordy;
    rr4          = rr;
    #1;
    check({tag, ".in_ready"}, {28'd0, b4.in_ready}, {28'd0, exp_irdy});
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, {31'd0, b4.out_valid}, {31'd0, exp_ov});
    check({tag, ".out_sel"}, {30'd0, b4.out_sel}, {30'd0, exp_sel});
    check({tag, ".out_data"}, b4.out_data, chdat[exp_sel]);
  endtask

  task automatic step3(input string tag, input logic [2:0] iv, input logic ordy, input logic rr,
                       input logic [2:0] exp_irdy, input logic exp_ov, input logic [1:0] exp_sel);
    b3.in_valid  = iv;
    b3.out_ready = ordy;
    rr3          = rr;
    #1;
    check({tag, ".in_ready"}, {29'd0, b3.in_ready}, {29'd0, exp_irdy});
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, {31'd0, b3.out_valid}, {31'd0, exp_ov});
    check({tag, ".out_sel"}, {30'd0, b3.out_sel}, {30'd0, exp_sel});
    check({tag, ".out_data"}, b3.out_data, chdat[exp_sel]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    chdat[0] = 32'h1111_0000;
    chdat[1] = 32'h2222_0001;
    chdat[2] = 32'hAAAA_0002;
    chdat[3] = 32'hBBBB_0003;

    //          iv       ordy  irdy     ov    sel
    tbl[0]  = '{4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2};  // lowest valid index wins
    tbl[1]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3};  // ch2 dropped, ch3 next
    tbl[2]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2'd3};  // stall 1
    tbl[3]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2'd3};  // stall 2
    tbl[4]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2'd3};  // stall 3
    tbl[5]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};  // drain and fill same edge
    tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};  // idle: valid drops, sel/data hold
    tbl[7]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};  // empty register, still idle
    tbl[8]  = '{4'b0110, 1'b0, 4'b0010, 1'b1, 2'd1};  // empty register loads despite !out_ready
    tbl[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};  // stall with all requesting
    tbl[10] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[11] = '{4'b1110, 1'b1, 4'b0010, 1'b1, 2'd1};

    b4.in_data   = {chdat[3], chdat[2], chdat[1], chdat[0]};
    b3.in_data   = {chdat[2], chdat[1], chdat[0]};
    b4.in_valid  = 4'b1111;
    b4.out_ready = 1'b1;
    b3.in_valid  = 3'b000;
    b3.out_ready = 1'b1;
    rr4 = 1'b0;
    rr3 = 1'b0;
    reset_n = 1'b0;

    // Reset held with every channel requesting.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst.out_valid", {31'd0, b4.out_valid}, 32'd0);
    check("rst.out_data", b4.out_data, 32'd0);
    check("rst.out_sel", {30'd0, b4.out_sel}, 32'd0);
    check("rst.in_ready", {28'd0, b4.in_ready}, 32'd0);
    check("rst.u3_out_valid", {31'd0, b3.out_valid}, 32'd0);
    reset_n = 1'b1;
    step4("rel", 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0);

    for (int v = 0; v < 12; v++) begin
      step4($sformatf("tbl%0d", v), tbl[v].iv, tbl[v].ordy, 1'b0, tbl[v].irdy, tbl[v].ov, tbl[v].sel);
    end

`ifdef PRIO_MUX_RR_EN
    // Pointer starts at 0: full rotation with wrap 3->0.
    step4("rr0", 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0);
    step4("rr1", 4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1);
    step4("rr2", 4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2);
    step4("rr3", 4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3);
    step4("rr4", 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0);
    step4("rr5", 4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1);
    // ptr=2, only ch0 valid: wraps to ch0, ptr becomes 1.
    step4("rrwrap", 4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0);
    // ptr=1 with 1001: skip to ch3, then ptr=0 picks ch0.
    step4("rrskip3", 4'b1001, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3);
    step4("rrskip0", 4'b1001, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0);
    // ptr=1; a fixed-mode transfer leaves it alone.
    step4("rrfix", 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0);
    step4("rrkeep", 4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1);

    step3("n3rr0", 3'b111, 1'b1, 1'b1, 3'b001, 1'b1, 2'd0);
    step3("n3rr1", 3'b111, 1'b1, 1'b1, 3'b010, 1'b1, 2'd1);
    step3("n3rr2", 3'b111, 1'b1, 1'b1, 3'b100, 1'b1, 2'd2);
    step3("n3rr3", 3'b111, 1'b1, 1'b1, 3'b001, 1'b1, 2'd0);
    step3("n3idle", 3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 2'd0);
`else
    // Without round-robin support rr_mode has no effect.
    step4("norr0", 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0);
    step4("norr1", 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0);
    step4("norr2", 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0);
    step4("norr3", 4'b1010, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1);

    step3("n3fix0", 3'b111, 1'b1, 1'b1, 3'b001, 1'b1, 2'd0);
    step3("n3fix1", 3'b111, 1'b1, 1'b1, 3'b001, 1'b1, 2'd0);
    step3("n3fix2", 3'b110, 1'b1, 1'b1, 3'b010, 1'b1, 2'd1);
    step3("n3fix3", 3'b100, 1'b1, 1'b1, 3'b100, 1'b1, 2'd2);
    step3("n3idle", 3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 2'd2);
`endif

    // Reset arriving during a stall drops the held beat at once.
    step4("pre", 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0);
    step4("stall", 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0);
    reset_n = 1'b0;
    #1;
    check("midrst.out_valid", {31'd0, b4.out_valid}, 32'd0);
    check("midrst.out_data", b4.out_data, 32'd0);
    check("midrst.in_ready", {28'd0, b4.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step4("post", 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
